aes_io_bridge: RTL and testbench

//  Byte-serial bridge between the Nios II PIO handshake ports and the AES controller.
//  - Inbound: collects a 128-bit ciphertext and a 128-bit key, one byte per four-phase handshake.
//  - Starts the AES controller, captures its 128-bit plaintext, and returns it byte-serially.
//  - Sits directly upstream of aes_controller and replaces the ad-hoc I/O path.

---
 rtl/aes_io_pkg.sv | 29 ++
 rtl/aes_io_sync.sv | 27 ++
 rtl/aes_io_bridge.sv | 133 +++++++++++++
 tb/tb_aes_io_bridge.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_io_pkg.sv
// Shared types and constants for the PIO <-> AES byte-serial bridge.
package aes_io_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int MSG_BYTES_DEF = 16;
  localparam int KEY_BYTES_DEF = 16;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_ACK,
    START,
    WAIT_AES,
    TX_IDLE,
    TX_ACK
  } io_state_t;

  // SW->HW command codes
  localparam logic [1:0] SIG_IDLE  = 2'b00;
  localparam logic [1:0] SIG_WR    = 2'b01;
  localparam logic [1:0] SIG_RD    = 2'b10;
  localparam logic [1:0] SIG_ABORT = 2'b11;

  // HW->SW status codes
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ACK   = 2'b01;
  localparam logic [1:0] ST_VALID = 2'b10;
  localparam logic [1:0] ST_BUSY  = 2'b11;

endpackage

// File: rtl/aes_io_sync.sv
// Two-flop synchroniser for level signals crossing into the clk domain.
module aes_io_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/aes_io_bridge.sv
// Byte-serial four-phase PIO bridge: gathers ciphertext+key for the AES core
// and streams the plaintext back, MSB byte first.
module aes_io_bridge
  import aes_io_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MSG_BYTES = MSG_BYTES_DEF,
  parameter int KEY_BYTES = KEY_BYTES_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [1:0]                    to_hw_sig,
  input  logic [DATA_W-1:0]             to_hw_port,
  output logic [1:0]                    to_sw_sig,
  output logic [DATA_W-1:0]             to_sw_port,
  output logic [MSG_BYTES*DATA_W-1:0]   msg_en,
  output logic [KEY_BYTES*DATA_W-1:0]   key,
  input  logic [MSG_BYTES*DATA_W-1:0]   msg_de,
  output logic                          io_ready,
  input  logic                          aes_ready
);

  localparam int         MSG_W   = MSG_BYTES * DATA_W;
  localparam int         KEY_W   = KEY_BYTES * DATA_W;
  localparam logic [5:0] MSG_CNT = 6'(MSG_BYTES);
  localparam logic [5:0] CNT_MAX = 6'(MSG_BYTES + KEY_BYTES);

  io_state_t         r_state;
  logic [5:0]        r_byte_cnt;
  logic [1:0]        r_to_sw_sig;
  logic [DATA_W-1:0] r_to_sw_port;
  logic [MSG_W-1:0]  r_msg_en;
  logic [KEY_W-1:0]  r_key;
  logic [MSG_W-1:0]  r_out_buf;
  logic              r_io_ready;

  logic [1:0]        w_sig;
  logic              w_aes_ready;
  logic [5:0]        w_cnt_inc;

  aes_io_sync #(.W(3)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     ({aes_ready, to_hw_sig}),
    .o_q     ({w_aes_ready, w_sig})
  );

  // Saturating increment: the counter parks at the full operand count.
  assign w_cnt_inc = (r_byte_cnt == CNT_MAX) ? r_byte_cnt : r_byte_cnt + 6'd1;

  // to_hw_port is not synchronised: it has been stable for two cycles by the
  // time the synchronised WR is decoded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= RX_IDLE;
      r_byte_cnt   <= '0;
      r_to_sw_sig  <= ST_IDLE;
      r_to_sw_port <= '0;
      r_msg_en     <= '0;
      r_key        <= '0;
      // NOTE: the result buffer is a plain register bank, so it is reset along with the rest.
      r_out_buf    <= '0;
      r_io_ready   <= 1'b0;
    end else if (w_sig == SIG_ABORT) begin
      r_state     <= RX_IDLE;
      r_byte_cnt  <= '0;
      r_io_ready  <= 1'b0;
      r_to_sw_sig <= ST_IDLE;
    end else begin
      case (r_state)
        RX_IDLE: begin
          if (w_sig == SIG_WR) begin
            if (r_byte_cnt < MSG_CNT)
              r_msg_en[MSG_W-1-DATA_W*int'(r_byte_cnt) -: DATA_W] <= to_hw_port;
            else if (r_byte_cnt < CNT_MAX)
              r_key[KEY_W-1-DATA_W*(int'(r_byte_cnt)-MSG_BYTES) -: DATA_W] <= to_hw_port;
            r_to_sw_sig <= ST_ACK;
            r_state     <= RX_ACK;
          end
        end
        RX_ACK: begin
          if (w_sig == SIG_IDLE) begin
            r_to_sw_sig <= ST_IDLE;
            r_byte_cnt  <= w_cnt_inc;
            r_state     <= (w_cnt_inc == CNT_MAX) ? START : RX_IDLE;
          end
        end
        START: begin
          r_io_ready  <= 1'b1;
          r_to_sw_sig <= ST_BUSY;
          r_state     <= WAIT_AES;
        end
        WAIT_AES: begin
          // Level-sensitive: a result already waiting is taken on the first cycle.
          if (w_aes_ready) begin
            r_out_buf   <= msg_de;
            r_io_ready  <= 1'b0;
            r_byte_cnt  <= '0;
            r_to_sw_sig <= ST_IDLE;
            r_state     <= TX_IDLE;
          end
        end
        TX_IDLE: begin
          if (w_sig == SIG_RD) begin
            r_to_sw_port <= r_out_buf[MSG_W-1-DATA_W*int'(r_byte_cnt) -: DATA_W];
            r_to_sw_sig  <= ST_VALID;
            r_state      <= TX_ACK;
          end
        end
        TX_ACK: begin
          if (w_sig == SIG_IDLE) begin
            r_to_sw_sig <= ST_IDLE;
            if (w_cnt_inc == MSG_CNT) begin
              r_byte_cnt <= '0;
              r_state    <= RX_IDLE;
            end else begin
              r_byte_cnt <= w_cnt_inc;
              r_state    <= TX_IDLE;
            end
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign to_sw_sig  = r_to_sw_sig;
  assign to_sw_port = r_to_sw_port;
  assign msg_en     = r_msg_en;
  assign key        = r_key;
  assign io_ready   = r_io_ready;

endmodule

// File: tb/tb_aes_io_bridge.sv
// Randomised scoreboard bench for aes_io_bridge: a host-side byte-image model
// predicts operands and returned bytes; a monitor compares what the DUT presents.
module tb_aes_io_bridge;
  import aes_io_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   to_hw_sig;
  logic [7:0]   to_hw_port;
  logic [1:0]   to_sw_sig;
  logic [7:0]   to_sw_port;
  logic [127:0] msg_en;
  logic [127:0] key;
  logic [127:0] msg_de;
  logic         io_ready;
  logic         aes_ready;

  always #5 clk = ~clk;

  aes_io_bridge dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .to_hw_sig  (to_hw_sig),
    .to_hw_port (to_hw_port),
    .to_sw_sig  (to_sw_sig),
    .to_sw_port (to_sw_port),
    .msg_en     (msg_en),
    .key        (key),
    .msg_de     (msg_de),
    .io_ready   (io_ready),
    .aes_ready  (aes_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Host view: 32-byte operand image, bytes written so far, expected outputs.
  logic [7:0]   img [32];
  int           m_cnt;
  logic [7:0]   exp_tx [$];
  logic [255:0] exp_op [$];

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [127:0] img_word(input int base);
    logic [127:0] w = '0;
    for (int i = 0; i < 16; i++) w = (w << 8) | 128'(img[base+i]);
    return w;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
    m_cnt = 0;
  endtask

  task automatic wait_sig(input logic [1:0] v, input string nm);
    logic seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (to_sw_sig == v) seen = 1'b1;
    end
    check(nm, 256'(seen), 256'(1));
  endtask

  task automatic wr_byte(input logic [7:0] b, input int hold = 0);
    img[m_cnt] = b;
    m_cnt++;
    if (m_cnt == 32) exp_op.push_back({img_word(0), img_word(16)});
    @(negedge clk);
    to_hw_port = b;
    to_hw_sig  = SIG_WR;
    wait_sig(ST_ACK, "wr_ack");
    repeat (hold) @(negedge clk);
    to_hw_sig = SIG_IDLE;
    wait_sig(ST_IDLE, "wr_ack_drop");
  endtask

  task automatic rd_byte();
    @(negedge clk);
    to_hw_sig = SIG_RD;
    wait_sig(ST_VALID, "rd_valid");
    to_hw_sig = SIG_IDLE;
    wait_sig(ST_IDLE, "rd_drop");
  endtask

  task automatic finish_aes(input logic [127:0] pt);
    logic seen = 1'b0;
    for (int i = 0; i < 16; i++) exp_tx.push_back(8'((pt >> (8 * (15 - i))) & 128'hFF));
    msg_de    = pt;
    aes_ready = 1'b1;
    m_cnt     = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (dut.r_state == TX_IDLE) seen = 1'b1;
    end
    check("capture_to_tx", 256'(seen), 256'(1));
    check("io_ready_low_after_capture", 256'(io_ready), 256'(0));
    aes_ready = 1'b0;
    for (int i = 0; i < 16; i++) rd_byte();
    check("state_rx_after_tx", 256'(dut.r_state), 256'(RX_IDLE));
    check("cnt_zero_after_tx", 256'(dut.r_byte_cnt), 256'(0));
  endtask

  task automatic do_abort();
    @(negedge clk);
    to_hw_sig = SIG_ABORT;
    repeat (4) @(negedge clk);
    to_hw_sig = SIG_IDLE;
    repeat (3) @(negedge clk);
    m_cnt = 0;
    check("abort_sig", 256'(to_sw_sig), 256'(ST_IDLE));
    check("abort_io_ready", 256'(io_ready), 256'(0));
    check("abort_state", 256'(dut.r_state), 256'(RX_IDLE));
    check("abort_cnt", 256'(dut.r_byte_cnt), 256'(0));
    check("abort_keeps_msg", 256'(msg_en), 256'(img_word(0)));
    check("abort_keeps_key", 256'(key), 256'(img_word(16)));
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) wr_byte(8'($urandom));
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: compares whatever the DUT presents against the queued predictions.
  logic [1:0]   mon_prev_sig = 2'b00;
  logic         mon_prev_rdy = 1'b0;
  logic [255:0] mon_op;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (to_sw_sig == ST_VALID && mon_prev_sig != ST_VALID) begin
        if (exp_tx.size() == 0) begin
          n_checks++;
          $display("FAIL tx_unexpected: got byte %0h, expected no RD_VALID", to_sw_port);
        end else begin
          check("tx_byte", 256'(to_sw_port), 256'(exp_tx.pop_front()));
        end
      end
      if (io_ready && !mon_prev_rdy) begin
        if (exp_op.size() == 0) begin
          n_checks++;
          $display("FAIL io_ready_unexpected: got rise, expected none");
        end else begin
          mon_op = exp_op.pop_front();
          check("msg_en_at_start", 256'(msg_en), 256'(mon_op[255:128]));
          check("key_at_start", 256'(key), 256'(mon_op[127:0]));
        end
      end
    end
    mon_prev_sig = to_sw_sig;
    mon_prev_rdy = io_ready;
  end

  initial begin
    logic         ok;
    logic [127:0] pt;

    reset_n    = 1'b0;
    to_hw_sig  = SIG_IDLE;
    to_hw_port = 8'h00;
    msg_de     = '0;
    aes_ready  = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sig", 256'(to_sw_sig), 256'(ST_IDLE));
    check("rst_port", 256'(to_sw_port), 256'(0));
    check("rst_msg", 256'(msg_en), 256'(0));
    check("rst_key", 256'(key), 256'(0));
    check("rst_io_ready", 256'(io_ready), 256'(0));
    check("rst_state", 256'(dut.r_state), 256'(RX_IDLE));

    // Reset in the middle of byte 5 (sixth byte) of a receive
    load_random(5);
    @(negedge clk);
    to_hw_port = 8'h5C;
    to_hw_sig  = SIG_WR;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    model_clear();
    check("midrst_sig", 256'(to_sw_sig), 256'(ST_IDLE));
    check("midrst_msg", 256'(msg_en), 256'(0));
    check("midrst_key", 256'(key), 256'(0));
    check("midrst_cnt", 256'(dut.r_byte_cnt), 256'(0));
    check("midrst_state", 256'(dut.r_state), 256'(RX_IDLE));
    to_hw_sig = SIG_IDLE;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    wr_byte(8'hA5);
    check("first_byte_msb", 256'(msg_en), 256'(img_word(0)));
    check("first_byte_cnt", 256'(dut.r_byte_cnt), 256'(1));
    do_abort();

    // Directed load 00..1F and io_ready timing after the last ack drops
    for (int i = 0; i < 32; i++) wr_byte(8'(i));
    check("io_ready_low_at_last_drop", 256'(io_ready), 256'(0));
    @(negedge clk);
    check("io_ready_rise", 256'(io_ready), 256'(1));
    check("busy_sig", 256'(to_sw_sig), 256'(ST_BUSY));
    check("dir_msg", 256'(msg_en), 256'(128'h000102030405060708090A0B0C0D0E0F));
    check("dir_key", 256'(key), 256'(128'h101112131415161718191A1B1C1D1E1F));

    // WR while waiting on AES gets no ack
    to_hw_port = 8'($urandom);
    to_hw_sig  = SIG_WR;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (to_sw_sig != ST_BUSY) ok = 1'b0;
    end
    check("busy_hold", 256'(ok), 256'(1));
    check("busy_msg_unchanged", 256'(msg_en), 256'(img_word(0)));
    to_hw_sig = SIG_IDLE;
    repeat (3) @(negedge clk);

    finish_aes(128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98);

    // Result already pending when WAIT_AES is entered
    pt        = rand128();
    msg_de    = pt;
    aes_ready = 1'b1;
    load_random(32);
    finish_aes(pt);

    // Abort after 20 bytes, then a full reload
    load_random(20);
    do_abort();
    load_random(32);
    finish_aes(rand128());

    // Held WR counts once; RD during RX is ignored
    wr_byte(8'($urandom), 50);
    check("held_wr_cnt", 256'(dut.r_byte_cnt), 256'(m_cnt));
    @(negedge clk);
    to_hw_sig = SIG_RD;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (to_sw_sig != ST_IDLE) ok = 1'b0;
    end
    check("rd_in_rx_ignored", 256'(ok), 256'(1));
    to_hw_sig = SIG_IDLE;
    repeat (3) @(negedge clk);
    check("rd_in_rx_cnt", 256'(dut.r_byte_cnt), 256'(m_cnt));
    check("rd_in_rx_msg", 256'(msg_en), 256'(img_word(0)));

    repeat (3) @(negedge clk);
    check("tx_queue_drained", 256'(exp_tx.size()), 256'(0));
    check("op_queue_drained", 256'(exp_op.size()), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
